mem_requester: RTL and testbench

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester_if.sv | 27 ++
 rtl/mem_requester.sv | 123 ++++++++++++
 tb/tb_mem_requester.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_requester_if.sv
// Core/arbiter handshake bundle for mem_requester; slave = requester side, master = core+arbiter side.
interface mem_requester_if;
    logic       start;
    logic       we;
    logic [7:0] addr_in;
    logic [7:0] wdata_in;
    logic       acq;
    logic [7:0] mem_rdata;
    logic       rden;
    logic       wren;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, we, addr_in, wdata_in, acq, mem_rdata,
        output rden, wren, mem_addr, mem_wdata, rdata, busy, done, err
    );

    modport master (
        output start, we, addr_in, wdata_in, acq, mem_rdata,
        input  rden, wren, mem_addr, mem_wdata, rdata, busy, done, err
    );
endinterface

// File: rtl/mem_requester.sv
// Single-beat load/store requester toward a memory arbiter; data lands LAT cycles after grant.
// Waits on acq with a TIMEOUT bound; a lost grant restarts the request; start is ignored while busy.
module mem_requester #(
    parameter int LAT     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_requester_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

    state_t     state_q, state_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] lat_q, lat_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rden_q, rden_d;
    logic       wren_q, wren_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        lat_d   = lat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr_in;
                    wdata_d = bus.wdata_in;
                    wait_d  = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A grant on the timeout edge still wins.
                if (bus.acq) begin
                    lat_d   = 4'(LAT);
                    state_d = HOLD;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HOLD: begin
                if (!bus.acq) begin
                    wait_d  = 8'd0;
                    state_d = REQ;
                end else if (lat_q == 4'd1) begin
                    if (!we_q) rdata_d = bus.mem_rdata;
                    lat_d   = 4'd0;
                    state_d = RELEASE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RELEASE: begin
                if (!bus.acq) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        rden_d = ((state_d == REQ) || (state_d == HOLD)) && !we_d;
        wren_d = ((state_d == REQ) || (state_d == HOLD)) && we_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            wait_q  <= 8'd0;
            lat_q   <= 4'd0;
            rdata_q <= 8'd0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.rden      = rden_q;
    assign bus.wren      = wren_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester (LAT=3, TIMEOUT=4): load, store, timeout, preemption, back-to-back, reset.
module tb_mem_requester;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mem_requester_if bus ();

    mem_requester #(.LAT(3), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.we = 1'b0; bus.addr_in = 8'h00; bus.wdata_in = 8'h00;
        bus.acq = 1'b0; bus.mem_rdata = 8'h00;
        cyc(); cyc();
        n_cmp++;
        if ({bus.rden, bus.wren, bus.busy, bus.done, bus.err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b want=00000", {bus.rden, bus.wren, bus.busy, bus.done, bus.err});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 24'h0) begin
            n_bad++; $display("FAIL reset_data got=%h want=000000", {bus.mem_addr, bus.mem_wdata, bus.rdata});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_load();
        bus.start = 1'b1; bus.we = 1'b0; bus.addr_in = 8'h12; bus.wdata_in = 8'hEE;
        cyc();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.rden, bus.wren, bus.mem_addr} !== {3'b110, 8'h12}) begin
            n_bad++; $display("FAIL load_req got=%b_%h want=110_12", {bus.busy, bus.rden, bus.wren}, bus.mem_addr);
        end
        cyc();
        bus.acq = 1'b1; bus.mem_rdata = 8'hA5;
        cyc(); cyc(); cyc();
        n_cmp++;
        if ({bus.rden, bus.rdata} !== {1'b1, 8'h00}) begin
            n_bad++; $display("FAIL load_pre_capture got=%b_%h want=1_00", bus.rden, bus.rdata);
        end
        cyc();
        n_cmp++;
        if ({bus.rden, bus.busy, bus.done, bus.rdata} !== {3'b010, 8'hA5}) begin
            n_bad++; $display("FAIL load_capture got=%b_%h want=010_a5", {bus.rden, bus.busy, bus.done}, bus.rdata);
        end
        cyc();
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_bad++; $display("FAIL load_release_wait got=%b want=10", {bus.busy, bus.done});
        end
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.done, bus.err, bus.busy, bus.rden} !== 4'b1000) begin
            n_bad++; $display("FAIL load_done got=%b want=1000", {bus.done, bus.err, bus.busy, bus.rden});
        end
        cyc();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++; $display("FAIL load_done_width got=%b want=0", bus.done);
        end
    endtask

    task automatic test_store();
        int wcnt;
        int rcnt;
        wcnt = 0; rcnt = 0;
        bus.start = 1'b1; bus.we = 1'b1; bus.addr_in = 8'h40; bus.wdata_in = 8'h3C;
        bus.acq = 1'b1; bus.mem_rdata = 8'h77;
        cyc();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h403C) begin
            n_bad++; $display("FAIL store_bus got=%h want=403c", {bus.mem_addr, bus.mem_wdata});
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.wren) wcnt++;
            if (bus.rden) rcnt++;
            cyc();
        end
        n_cmp++;
        if (wcnt !== 4) begin
            n_bad++; $display("FAIL store_wren_cycles got=%0d want=4", wcnt);
        end
        n_cmp++;
        if (rcnt !== 0) begin
            n_bad++; $display("FAIL store_rden_cycles got=%0d want=0", rcnt);
        end
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.done, bus.err, bus.rdata} !== {2'b10, 8'hA5}) begin
            n_bad++; $display("FAIL store_done got=%b_%h want=10_a5", {bus.done, bus.err}, bus.rdata);
        end
    endtask

    task automatic test_timeout();
        int  rcnt;
        bit  found;
        rcnt = 0; found = 1'b0;
        bus.start = 1'b1; bus.we = 1'b0; bus.addr_in = 8'h21;
        bus.acq = 1'b0;
        cyc();
        bus.start = 1'b0;
        if (bus.rden) rcnt++;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (bus.err) found = 1'b1;
            else if (bus.rden) rcnt++;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++; $display("FAIL timeout_seen got=%b want=1", found);
        end
        n_cmp++;
        if (rcnt !== 4) begin
            n_bad++; $display("FAIL timeout_rden_cycles got=%0d want=4", rcnt);
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.rden, bus.rdata} !== {3'b100, 8'hA5}) begin
            n_bad++; $display("FAIL timeout_state got=%b_%h want=100_a5", {bus.done, bus.busy, bus.rden}, bus.rdata);
        end
        cyc();
        n_cmp++;
        if ({bus.err, bus.done} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_pulse_width got=%b want=00", {bus.err, bus.done});
        end
    endtask

    task automatic test_preempt();
        bus.start = 1'b1; bus.we = 1'b0; bus.addr_in = 8'h66;
        cyc();
        bus.start = 1'b0;
        bus.acq = 1'b1; bus.mem_rdata = 8'h11;
        cyc(); cyc();
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.rden, bus.busy, bus.rdata} !== {2'b11, 8'hA5}) begin
            n_bad++; $display("FAIL preempt_back_to_req got=%b_%h want=11_a5", {bus.rden, bus.busy}, bus.rdata);
        end
        bus.acq = 1'b1; bus.mem_rdata = 8'h5A;
        cyc(); cyc(); cyc();
        n_cmp++;
        if ({bus.rden, bus.rdata} !== {1'b1, 8'hA5}) begin
            n_bad++; $display("FAIL preempt_pre_capture got=%b_%h want=1_a5", bus.rden, bus.rdata);
        end
        cyc();
        n_cmp++;
        if (bus.rdata !== 8'h5A) begin
            n_bad++; $display("FAIL preempt_capture got=%h want=5a", bus.rdata);
        end
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++; $display("FAIL preempt_done got=%b want=1", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1; bus.we = 1'b1; bus.addr_in = 8'h30; bus.wdata_in = 8'h01;
        bus.acq = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.start = 1'b1; bus.addr_in = 8'h99; bus.wdata_in = 8'hFF;
        cyc();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.busy} !== {8'h30, 8'h01, 1'b1}) begin
            n_bad++; $display("FAIL b2b_ignore_busy got=%h_%h_%b want=30_01_1", bus.mem_addr, bus.mem_wdata, bus.busy);
        end
        cyc(); cyc();
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_first_done got=%b want=10", {bus.done, bus.busy});
        end
        bus.start = 1'b1; bus.we = 1'b0; bus.addr_in = 8'h55;
        cyc();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.mem_addr, bus.busy, bus.rden, bus.wren} !== {8'h55, 3'b110}) begin
            n_bad++; $display("FAIL b2b_accept got=%h_%b want=55_110", bus.mem_addr, {bus.busy, bus.rden, bus.wren});
        end
        bus.acq = 1'b1; bus.mem_rdata = 8'hC3;
        cyc(); cyc(); cyc(); cyc();
        bus.acq = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.done, bus.rdata} !== {1'b1, 8'hC3}) begin
            n_bad++; $display("FAIL b2b_second_done got=%b_%h want=1_c3", bus.done, bus.rdata);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int dcnt;
        dcnt = 0;
        bus.start = 1'b1; bus.we = 1'b0; bus.addr_in = 8'h7E;
        bus.acq = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rden, bus.wren, bus.busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_async_ctrl got=%b want=000", {bus.rden, bus.wren, bus.busy});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.err} !== 26'h0) begin
            n_bad++; $display("FAIL rst_async_data got=%h want=0", {bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.err});
        end
        cyc();
        bus.acq = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.done) dcnt++;
        end
        n_cmp++;
        if (dcnt !== 0) begin
            n_bad++; $display("FAIL rst_no_done got=%0d want=0", dcnt);
        end
        bus.start = 1'b1; bus.we = 1'b1; bus.addr_in = 8'h0F; bus.wdata_in = 8'h42;
        cyc();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.wren, bus.busy, bus.mem_addr, bus.mem_wdata} !== {2'b11, 8'h0F, 8'h42}) begin
            n_bad++; $display("FAIL rst_first_start got=%b_%h_%h want=11_0f_42", {bus.wren, bus.busy}, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_preempt();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
